// File: rtl/kbd_event_arb.sv
// Arbitrates NREQ valid/ready key-event sources onto one {release,code} strobe path with
// optional per-source pacing. Define KBD_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module kbd_event_arb #(
  parameter int          NREQ       = 2,
  parameter logic [23:0] GAP_CYCLES = 24'd7000000,
  parameter logic [7:0]  PACED_MASK = 8'b10
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [9*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                ev_strobe,
  output logic                ev_release,
  output logic [7:0]          ev_code,
  output logic [2:0]          ev_src,
  output logic                busy
);

  logic [23:0]     r_gap_cnt [NREQ];
  logic [NREQ-1:0] w_gap_busy;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [2:0]      w_win;
  logic [8:0]      w_data;
  logic            w_any;

  // Eligibility: valid, gap expired, enabled; reset also masks the combinational grant
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_gap_busy[i] = (r_gap_cnt[i] != 24'd0);
    end
    w_elig = req_valid & ~w_gap_busy & {NREQ{enable & reset_n}};
  end

`ifdef KBD_ARB_FIXED_PRIO_EN
  // Fixed priority: scanning downward leaves the lowest eligible index as winner
  always_comb begin
    w_gnt  = '0;
    w_win  = 3'd0;
    w_data = 9'h000;
    w_any  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_gnt    = '0;
        w_gnt[k] = 1'b1;
        w_win    = 3'(k);
        w_data   = req_data[9*k +: 9];
        w_any    = 1'b1;
      end
    end
  end
`else
  logic [2:0] r_rr;
  int         w_idx;

  // Round-robin from rr+1; scanning offsets downward leaves the nearest one as winner
  always_comb begin
    w_gnt  = '0;
    w_win  = 3'd0;
    w_data = 9'h000;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int off = NREQ; off >= 1; off--) begin
      w_idx = (int'(r_rr) + off) % NREQ;
      if (w_elig[w_idx]) begin
        w_gnt        = '0;
        w_gnt[w_idx] = 1'b1;
        w_win        = 3'(w_idx);
        w_data       = req_data[9*w_idx +: 9];
        w_any        = 1'b1;
      end
    end
  end

  // Pointer starts at the last requester so requester 0 wins first after reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rr <= 3'(NREQ - 1);
    end else if (w_any) begin
      r_rr <= w_win;
    end else begin
      r_rr <= r_rr;
    end
  end
`endif

  // Paced sources reload on grant (delay tokens included); everything else drains to zero
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) begin
        r_gap_cnt[i] <= 24'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (PACED_MASK[i] && (GAP_CYCLES != 24'd0) && w_gnt[i]) begin
          r_gap_cnt[i] <= GAP_CYCLES - 24'd1;
        end else if (w_gap_busy[i]) begin
          r_gap_cnt[i] <= r_gap_cnt[i] - 24'd1;
        end else begin
          r_gap_cnt[i] <= 24'd0;
        end
      end
    end
  end

  // Event register: one strobe the cycle after a grant, suppressed for the 9'h000 token
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ev_strobe  <= 1'b0;
      ev_release <= 1'b0;
      ev_code    <= 8'h00;
      ev_src     <= 3'd0;
    end else begin
      ev_strobe <= w_any && (w_data != 9'h000);
      if (w_any && (w_data != 9'h000)) begin
        ev_release <= w_data[8];
        ev_code    <= w_data[7:0];
        ev_src     <= w_win;
      end else begin
        ev_release <= ev_release;
        ev_code    <= ev_code;
        ev_src     <= ev_src;
      end
    end
  end

  assign req_ready = w_gnt;
  assign busy      = reset_n & ((|req_valid) | (|w_gap_busy));

endmodule

// File: tb/tb_kbd_event_arb.sv
// Scoreboard bench for kbd_event_arb: dut_a is unpaced (GAP_CYCLES=0), dut_b paces requester 1
// with GAP_CYCLES=5. Expected events are queued at grant time and matched against ev_strobe.
`timescale 1ns/1ps
module tb_kbd_event_arb;

`ifdef KBD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_en = 1'b1, b_en = 1'b1;
  logic [1:0]  a_valid = 2'b00, b_valid = 2'b00;
  logic [17:0] a_data = 18'h0, b_data = 18'h0;
  logic [1:0]  a_ready, b_ready;
  logic        a_stb, a_rel, a_busy, b_stb, b_rel, b_busy;
  logic [7:0]  a_code, b_code;
  logic [2:0]  a_src, b_src;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         d;
    int         cyc;
    logic       rel;
    logic [7:0] code;
    logic [2:0] src;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kbd_event_arb #(.NREQ(2), .GAP_CYCLES(24'd0), .PACED_MASK(8'b10)) dut_a (
    .clk_sys(clk), .reset_n(reset_n), .enable(a_en), .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .ev_strobe(a_stb), .ev_release(a_rel), .ev_code(a_code),
    .ev_src(a_src), .busy(a_busy));

  kbd_event_arb #(.NREQ(2), .GAP_CYCLES(24'd5), .PACED_MASK(8'b10)) dut_b (
    .clk_sys(clk), .reset_n(reset_n), .enable(b_en), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .ev_strobe(b_stb), .ev_release(b_rel), .ev_code(b_code),
    .ev_src(b_src), .busy(b_busy));

  task automatic push(input int d, input logic rel, input logic [7:0] code, input logic [2:0] src);
    ev_t e;
    e.d = d; e.cyc = cyc + 1; e.rel = rel; e.code = code; e.src = src;
    sb.push_back(e);
  endtask

  task automatic mon(input int d, input logic stb, input logic rel, input logic [7:0] code,
                     input logic [2:0] src);
    ev_t e;
    if (stb) begin
      n_tests++;
      if (sb.size() == 0 || sb[0].cyc != cyc || sb[0].d != d) begin
        n_fail++;
        $display("FAIL unexpected_strobe dut%0d cyc %0d: got code %h src %0d, required no strobe",
                 d, cyc, code, src);
      end else begin
        e = sb.pop_front();
        if ({rel, code, src} !== {e.rel, e.code, e.src}) begin
          n_fail++;
          $display("FAIL ev_data dut%0d cyc %0d: got rel %b code %h src %0d, required rel %b code %h src %0d",
                   d, cyc, rel, code, src, e.rel, e.code, e.src);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].d == d) begin
      n_tests++;
      n_fail++;
      e = sb.pop_front();
      $display("FAIL missing_strobe dut%0d cyc %0d: got no strobe, required code %h", d, cyc, e.code);
    end
  endtask

  // Strobe monitor for both instances
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL late_strobe dut%0d: got nothing by cyc %0d, required code %h in cyc %0d",
               sb[0].d, cyc, sb[0].code, sb[0].cyc);
      void'(sb.pop_front());
    end
    mon(0, a_stb, a_rel, a_code, a_src);
    mon(1, b_stb, b_rel, b_code, b_src);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    a_valid = 2'b00; b_valid = 2'b00; a_en = 1'b1; b_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending events, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    a_valid = 2'b11; b_valid = 2'b11;
    a_data = {9'h111, 9'h022}; b_data = {9'h111, 9'h022};
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a_ready, a_stb, a_rel, a_code, a_src, a_busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %h, required 0", {a_ready, a_stb, a_rel, a_code, a_src, a_busy});
    end
    n_tests++;
    if ({b_ready, b_stb, b_rel, b_code, b_src, b_busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %h, required 0", {b_ready, b_stb, b_rel, b_code, b_src, b_busy});
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    a_valid = 2'b01; a_data = {9'h000, 9'h01C};
    @(negedge clk);
    n_tests++;
    if (a_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_ready: got %b, required 01", a_ready);
    end
    push(0, 1'b0, 8'h1C, 3'd0);
    @(posedge clk); #1;
    a_valid = 2'b00;
    drain("basic");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    a_valid = 2'b11; a_data = {9'h122, 9'h011};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
      n_tests++;
      if (a_ready !== exp) begin
        n_fail++;
        $display("FAIL rr_ready k=%0d: got %b, required %b", k, a_ready, exp);
      end
      if (exp == 2'b01) push(0, 1'b0, 8'h11, 3'd0);
      else              push(0, 1'b1, 8'h22, 3'd1);
      @(posedge clk); #1;
    end
    a_valid = 2'b00;
    drain("rr");
  endtask

  task automatic test_pacing();
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      b_valid = {1'b1, (k % 5 != 0)};
      b_data  = {1'b0, 8'(8'h30 + k / 5), 1'b1, 8'(8'h40 + k)};
      @(negedge clk);
      exp = (k % 5 == 0) ? 2'b10 : 2'b01;
      n_tests++;
      if (b_ready !== exp || b_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pace k=%0d: got ready %b busy %b, required ready %b busy 1", k, b_ready, b_busy, exp);
      end
      if (exp == 2'b10) push(1, 1'b0, 8'(8'h30 + k / 5), 3'd1);
      else              push(1, 1'b1, 8'(8'h40 + k), 3'd0);
      @(posedge clk); #1;
    end
    b_valid = 2'b00;
    drain("pace");
  endtask

  task automatic test_delay_token();
    logic [1:0] exp;
    do_reset();
    b_valid = 2'b10; b_data = {9'h000, 9'h000};
    @(negedge clk);
    n_tests++;
    if (b_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL token_ready: got %b, required 10", b_ready);
    end
    @(posedge clk); #1;
    b_data = {9'h15A, 9'h000};
    for (int k = 1; k <= 10; k++) begin
      b_valid = (k <= 5) ? 2'b10 : 2'b00;
      @(negedge clk);
      exp = (k == 5) ? 2'b10 : 2'b00;
      n_tests++;
      if (b_ready !== exp) begin
        n_fail++;
        $display("FAIL token_gap k=%0d: got %b, required %b", k, b_ready, exp);
      end
      if (k == 5) push(1, 1'b1, 8'h5A, 3'd1);
      if (k == 6 || k == 10) begin
        n_tests++;
        if (b_busy !== (k == 6)) begin
          n_fail++;
          $display("FAIL token_busy k=%0d: got %b, required %b", k, b_busy, (k == 6));
        end
      end
      @(posedge clk); #1;
    end
    drain("token");
  endtask

  task automatic test_enable();
    do_reset();
    b_en = 1'b0; b_valid = 2'b11; b_data = {9'h144, 9'h033};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (b_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL enable_off k=%0d: got %b, required 00", k, b_ready);
      end
      @(posedge clk); #1;
    end
    b_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (b_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL enable_on: got %b, required 01", b_ready);
    end
    push(1, 1'b0, 8'h33, 3'd0);
    @(posedge clk); #1;
    b_valid = 2'b00;
    drain("enable");
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    b_valid = 2'b10; b_data = {9'h01C, 9'h000};
    @(negedge clk);
    n_tests++;
    if (b_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_first: got %b, required 10", b_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    n_tests++;
    if ({b_ready, b_stb, b_rel, b_code, b_src, b_busy} !== 15'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h, required 0", {b_ready, b_stb, b_rel, b_code, b_src, b_busy});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (b_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_regrant: got %b, required 10", b_ready);
    end
    push(1, 1'b0, 8'h1C, 3'd1);
    @(posedge clk); #1;
    b_valid = 2'b00;
    drain("midrst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_pacing();
    test_delay_token();
    test_enable();
    test_reset_mid_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
